// File: rtl/fortaegis_pkg.sv
// Shared types and default sizing for the Fortaegis histogram chain.
package fortaegis_pkg;

    localparam int unsigned HISTO_BIN_AW = 4;
    localparam int unsigned HISTO_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } histo_rd_state_t;

    function automatic logic histo_rd_busy(input histo_rd_state_t s);
        return (s == ST_READ) || (s == ST_DRAIN) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/histo_skid_buf.sv
// Two-entry valid/ready skid buffer with registered output; the caller
// guarantees it never pushes into a full buffer and uses `count` for credit.
module histo_skid_buf
    import fortaegis_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [1:0]   cnt;
    logic         pop;

    assign pop = (cnt != 2'd0) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= in_data;
                    else             tail <= in_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: the new entry lands behind any held one.
                    if (cnt == 2'd2) begin
                        head <= tail;
                        tail <= in_data;
                    end else begin
                        head <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (cnt != 2'd0);
    assign out_data  = head;
    assign count     = cnt;

endmodule

// File: rtl/histo_readout.sv
// Histogram bin readout: sweeps bin memory after collection ends and streams
// one beat per bin. Define HISTO_CLR_ON_READ_EN to clear each bin once read.
module histo_readout
    import fortaegis_pkg::*;
#(
    parameter int unsigned BIN_AW = HISTO_BIN_AW,
    parameter int unsigned CNT_W  = HISTO_CNT_W
) (
    input  logic                     clk350,
    input  logic                     rst,
    input  logic                     collect,
    output logic                     mem_rd_en,
    output logic [BIN_AW-1:0]        mem_rd_addr,
    input  logic [CNT_W-1:0]         mem_rd_data,
    output logic                     mem_wr_en,
    output logic [BIN_AW-1:0]        mem_wr_addr,
    output logic [CNT_W-1:0]         mem_wr_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BIN_AW-1:0]        out_bin,
    output logic [CNT_W-1:0]         out_cnt,
    output logic                     out_last,
    output logic [CNT_W+BIN_AW-1:0]  total,
    output logic [BIN_AW-1:0]        peak_bin,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned TOT_W = CNT_W + BIN_AW;
    localparam int unsigned PW    = BIN_AW + CNT_W + 1;
    localparam logic [BIN_AW-1:0] LAST_ADDR = '1;

    histo_rd_state_t state, state_nxt;

    logic              busy_i;
    logic              collect_g;
    logic              start;
    logic              issue;
    logic              pop;
    logic [2:0]        credit;
    logic [1:0]        occ;
    logic [BIN_AW-1:0] rd_addr;
    logic              rd_pend;
    logic [BIN_AW-1:0] rd_pend_addr;
    logic [TOT_W-1:0]  total_q;
    logic [BIN_AW-1:0] peak_bin_q;
    logic [CNT_W-1:0]  peak_val;
    logic [PW-1:0]     skid_in;
    logic [PW-1:0]     skid_out;

    assign busy_i    = histo_rd_busy(state);
    assign collect_g = collect & ~busy_i;
    assign start     = (state == ST_ARMED) && !collect_g;
    assign pop       = out_valid && out_ready;

    // Reads in flight plus buffered beats, minus the beat leaving this cycle,
    // must stay below the buffer depth so nothing is ever dropped.
    assign credit = {2'b00, rd_pend} + {1'b0, occ} - {2'b00, pop};
    assign issue  = (state == ST_READ) && (credit < 3'd2);

    always_ff @(posedge clk350 or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (collect_g) state_nxt = ST_ARMED;
            ST_ARMED: if (!collect_g) state_nxt = ST_READ;
            ST_READ:  if (issue && (rd_addr == LAST_ADDR)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pop && out_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk350 or posedge rst) begin
        if (rst) begin
            rd_addr      <= '0;
            rd_pend      <= 1'b0;
            rd_pend_addr <= '0;
        end else begin
            rd_pend <= issue;
            if (start) begin
                rd_addr <= '0;
            end else if (issue) begin
                rd_addr      <= rd_addr + BIN_AW'(1);
                rd_pend_addr <= rd_addr;
            end
        end
    end

    always_ff @(posedge clk350 or posedge rst) begin
        if (rst) begin
            total_q    <= '0;
            peak_bin_q <= '0;
            peak_val   <= '0;
        end else if (start) begin
            total_q    <= '0;
            peak_bin_q <= '0;
            peak_val   <= '0;
        end else if (rd_pend) begin
            total_q <= total_q + TOT_W'(mem_rd_data);
            if (mem_rd_data > peak_val) begin
                peak_val   <= mem_rd_data;
                peak_bin_q <= rd_pend_addr;
            end
        end
    end

    assign skid_in = {rd_pend_addr, mem_rd_data, rd_pend_addr == LAST_ADDR};

    histo_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk       (clk350),
        .rst       (rst),
        .in_valid  (rd_pend),
        .in_data   (skid_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out),
        .count     (occ)
    );

    assign {out_bin, out_cnt, out_last} = skid_out;

    assign mem_rd_en   = issue;
    assign mem_rd_addr = rd_addr;
    assign mem_wr_addr = rd_pend_addr;
    assign mem_wr_data = '0;
`ifdef HISTO_CLR_ON_READ_EN
    assign mem_wr_en   = rd_pend;
`else
    assign mem_wr_en   = 1'b0;
`endif

    assign total    = total_q;
    assign peak_bin = peak_bin_q;
    assign busy     = busy_i;
    assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_histo_readout.sv
// Self-checking bench for histo_readout: table-driven sweeps plus randomized
// memory images and backpressure, checked against a behavioural bin model.
module tb_histo_readout;

    localparam int unsigned BIN_AW = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned NB     = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    collect;
    logic                    mem_rd_en;
    logic [BIN_AW-1:0]       mem_rd_addr;
    logic [CNT_W-1:0]        mem_rd_data;
    logic                    mem_wr_en;
    logic [BIN_AW-1:0]       mem_wr_addr;
    logic [CNT_W-1:0]        mem_wr_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [BIN_AW-1:0]       out_bin;
    logic [CNT_W-1:0]        out_cnt;
    logic                    out_last;
    logic [CNT_W+BIN_AW-1:0] total;
    logic [BIN_AW-1:0]       peak_bin;
    logic                    busy;
    logic                    done;

    histo_readout #(.BIN_AW(BIN_AW), .CNT_W(CNT_W)) dut (
        .clk350      (clk),
        .rst         (rst),
        .collect     (collect),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bin     (out_bin),
        .out_cnt     (out_cnt),
        .out_last    (out_last),
        .total       (total),
        .peak_bin    (peak_bin),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bin memory with one-cycle read latency; loads come from the bench image.
    logic [CNT_W-1:0] mem     [NB];
    logic [CNT_W-1:0] img     [NB];
    logic [CNT_W-1:0] exp_mem [NB];
    logic             load_req = 1'b0;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        if (load_req)       mem <= img;
        else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    typedef struct packed {
        logic [BIN_AW-1:0] bin;
        logic [CNT_W-1:0]  cnt;
        logic              last;
    } beat_t;

    beat_t beats[$];
    int    wr_count = 0;
    beat_t prev_beat;
    logic  prev_stall = 1'b0;

    always @(negedge clk) begin
        beat_t cur;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            cur = {out_bin, out_cnt, out_last};
            if (prev_stall) check("beat_hold", {out_valid, cur}, {1'b1, prev_beat});
            if (out_valid && out_ready) beats.push_back(cur);
            if (mem_wr_en) wr_count++;
            prev_stall = out_valid && !out_ready;
            prev_beat  = cur;
        end
    end

    task automatic set_pattern(input int p);
        for (int k = 0; k < NB; k++) begin
            case (p)
                0: img[k] = CNT_W'(k + 1);
                1: img[k] = (k == 3 || k == 9) ? 16'hFFFF : 16'h0000;
                default: begin
                    case ($urandom_range(0, 2))
                        0:       img[k] = 16'hFFFF;
                        1:       img[k] = CNT_W'($urandom_range(0, 3));
                        default: img[k] = CNT_W'($urandom_range(0, 65535));
                    endcase
                end
            endcase
        end
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    task automatic start_sweep(input int mode, output int n);
        exp_mem    = mem;
        beats.delete();
        wr_count   = 0;
        ready_mode = mode;
        @(posedge clk); #1 collect = 1'b1;
        repeat (10) @(posedge clk);
        #1 collect = 1'b0;
        n = cyc;
    endtask

    task automatic wait_done(output int dc, output bit ok);
        ok = 1'b0;
        dc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                dc = cyc;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done pulse, required one within 400 cycles");
        end
    endtask

    task automatic check_sweep(input string tag, input int n, input int dc, input bit chk_lat);
        logic [CNT_W+BIN_AW-1:0] ref_tot = '0;
        logic [BIN_AW-1:0]       ref_pk  = '0;
        logic [CNT_W-1:0]        ref_pv  = '0;
        beat_t                   e;
        int                      nz = 0;
        for (int i = 0; i < NB; i++) begin
            ref_tot += (CNT_W + BIN_AW)'(exp_mem[i]);
            if (exp_mem[i] > ref_pv) begin
                ref_pv = exp_mem[i];
                ref_pk = BIN_AW'(i);
            end
        end
        check({tag, " beat_count"}, beats.size(), NB);
        for (int i = 0; i < NB && i < beats.size(); i++) begin
            e.bin  = BIN_AW'(i);
            e.cnt  = exp_mem[i];
            e.last = (i == NB - 1);
            check($sformatf("%s beat%0d", tag, i), beats[i], e);
        end
        check({tag, " total"}, total, ref_tot);
        check({tag, " peak_bin"}, peak_bin, ref_pk);
        if (chk_lat) check({tag, " done_latency"}, dc - n, NB + 3);
        for (int i = 0; i < NB; i++) if (mem[i] != (`ifdef HISTO_CLR_ON_READ_EN 16'h0 `else exp_mem[i] `endif)) nz++;
        check({tag, " mem_after"}, nz, 0);
`ifdef HISTO_CLR_ON_READ_EN
        check({tag, " clear_writes"}, wr_count, NB);
`else
        check({tag, " clear_writes"}, wr_count, 0);
`endif
    endtask

    typedef struct {
        int                      pattern;
        int                      mode;
        logic [CNT_W+BIN_AW-1:0] exp_total;
        logic [BIN_AW-1:0]       exp_peak;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, dc;
        bit ok;

`ifdef HISTO_CLR_ON_READ_EN
        vecs[1] = '{-1, 0, 20'd0,   4'd0};
`else
        vecs[1] = '{-1, 0, 20'd136, 4'd15};
`endif
        vecs[0] = '{0, 0, 20'd136,     4'd15};
        vecs[2] = '{0, 1, 20'd136,     4'd15};
        vecs[3] = '{1, 0, 20'h1FFFE,   4'd3};
        vecs[4] = '{1, 2, 20'h1FFFE,   4'd3};

        rst       = 1'b1;
        collect   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_stream", {out_valid, out_bin, out_cnt, out_last, total, peak_bin, busy, done}, '0);
        check("reset_mem", {mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data}, '0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_no_sweep", {busy, mem_rd_en, out_valid}, '0);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].pattern >= 0) set_pattern(vecs[v].pattern);
            start_sweep(vecs[v].mode, n);
            wait_done(dc, ok);
            if (ok) begin
                check_sweep($sformatf("vec%0d", v), n, dc, vecs[v].mode == 0);
                check($sformatf("vec%0d tbl_total", v), total, vecs[v].exp_total);
                check($sformatf("vec%0d tbl_peak", v), peak_bin, vecs[v].exp_peak);
            end
        end

        // collect raised mid-sweep is ignored; the sweep still finishes
        set_pattern(0);
        start_sweep(0, n);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (beats.size() >= 5) break;
        end
        collect = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (beats.size() >= 10) break;
        end
        collect = 1'b0;
        wait_done(dc, ok);
        if (ok) check_sweep("collect_busy", n, dc, 1'b1);
        repeat (5) @(negedge clk);
        check("collect_busy idle", {busy, mem_rd_en, out_valid}, '0);

        // reset mid-sweep aborts everything at once
        set_pattern(2);
        start_sweep(0, n);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (beats.size() >= 7) break;
        end
        check("pre_reset beats", beats.size(), 7);
        for (int i = 0; i < 7 && i < beats.size(); i++)
            check($sformatf("pre_reset beat%0d", i), beats[i].cnt, exp_mem[i]);
        rst = 1'b1;
        #1;
        check("midrst_stream", {out_valid, out_bin, out_cnt, out_last, total, peak_bin, busy, done}, '0);
        check("midrst_mem", {mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data}, '0);
        wr_count = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_reset writes", wr_count, 0);
        check("post_reset idle", {busy, mem_rd_en, out_valid}, '0);

        for (int r = 0; r < 4; r++) begin
            set_pattern(2);
            start_sweep((r == 0) ? 0 : 2, n);
            wait_done(dc, ok);
            if (ok) check_sweep($sformatf("rand%0d", r), n, dc, r == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
